// File: rtl/echo_client_scheduler_if.sv
//==============================================================================
// Module : echo_client_scheduler_if
// Client-side and Echo-engine-side handshake bundle for the client scheduler.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface echo_client_scheduler_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = 32
);
  logic [NUM_CLIENTS-1:0]        client_say__ENA;
  logic [NUM_CLIENTS*DATA_W-1:0] client_say_meth;
  logic [NUM_CLIENTS*DATA_W-1:0] client_say_v;
  logic [NUM_CLIENTS-1:0]        client_say__RDY;
  logic [NUM_CLIENTS-1:0]        client_heard__ENA;
  logic [DATA_W-1:0]             client_heard_meth;
  logic [DATA_W-1:0]             client_heard_v;
  logic [NUM_CLIENTS-1:0]        client_heard__RDY;
  logic                          echo_say__ENA;
  logic [DATA_W-1:0]             echo_say_meth;
  logic [DATA_W-1:0]             echo_say_v;
  logic                          echo_say__RDY;
  logic                          echo_heard__ENA;
  logic [DATA_W-1:0]             echo_heard_meth;
  logic [DATA_W-1:0]             echo_heard_v;
  logic                          echo_heard__RDY;
  logic [1:0]                    echo_rule_enable;
  logic [1:0]                    echo_rule_ready;
  logic                          sched_enable;
  logic [31:0]                   issued_count;
  logic [31:0]                   completed_count;

  // Scheduler side
  modport slave (
    input  client_say__ENA, client_say_meth, client_say_v, client_heard__RDY,
    input  echo_say__RDY, echo_heard__ENA, echo_heard_meth, echo_heard_v,
    input  echo_rule_ready, sched_enable,
    output client_say__RDY, client_heard__ENA, client_heard_meth, client_heard_v,
    output echo_say__ENA, echo_say_meth, echo_say_v, echo_heard__RDY,
    output echo_rule_enable, issued_count, completed_count
  );

  // Environment side (clients plus engine)
  modport master (
    output client_say__ENA, client_say_meth, client_say_v, client_heard__RDY,
    output echo_say__RDY, echo_heard__ENA, echo_heard_meth, echo_heard_v,
    output echo_rule_ready, sched_enable,
    input  client_say__RDY, client_heard__ENA, client_heard_meth, client_heard_v,
    input  echo_say__ENA, echo_say_meth, echo_say_v, echo_heard__RDY,
    input  echo_rule_enable, issued_count, completed_count
  );
endinterface

`default_nettype wire

// File: rtl/echo_client_scheduler.sv
//==============================================================================
// Module : echo_client_scheduler
// Round-robin sharing of one in-order Echo engine; a tag FIFO steers responses.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module echo_client_scheduler #(
  parameter int NUM_CLIENTS = 4,
  parameter int TAG_DEPTH   = 2,
  parameter int DATA_W      = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  echo_client_scheduler_if.slave bus
);

  localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int OW = $clog2(TAG_DEPTH + 1);
  localparam logic [OW-1:0] c_DEPTH    = OW'(TAG_DEPTH);
  localparam logic [PW-1:0] c_LAST_PTR = PW'(TAG_DEPTH - 1);

  logic [CW-1:0] r_rr_ptr;
  logic [CW-1:0] r_tags [TAG_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [OW-1:0] r_occ;
  logic [31:0]   r_issued;
  logic [31:0]   r_completed;

  logic                   w_can_issue;
  logic                   w_blocked;
  logic [CW-1:0]          w_idx;
  logic [CW-1:0]          w_win;
  logic [CW-1:0]          w_sel;
  logic [NUM_CLIENTS-1:0] w_rdy;
  logic                   w_fire;
  logic [CW-1:0]          w_head;
  logic                   w_occ_nz;
  logic                   w_head_rdy;
  logic                   w_pop;
  logic [PW-1:0]          w_rd_next;
  logic [PW-1:0]          w_wr_next;

  // A full FIFO blocks issue even when a pop lands in the same cycle.
  assign w_can_issue = bus.sched_enable & bus.echo_say__RDY & (r_occ < c_DEPTH);

  // Grant goes to the first requester in rr order; RDY[i] never looks at ENA[i].
  always_comb begin
    w_rdy     = '0;
    w_blocked = 1'b0;
    w_win     = r_rr_ptr;
    w_idx     = r_rr_ptr;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      w_idx        = r_rr_ptr + CW'(k);
      w_rdy[w_idx] = w_can_issue & ~w_blocked;
      if (bus.client_say__ENA[w_idx] && !w_blocked) begin
        w_win = w_idx;
      end
      w_blocked    = w_blocked | bus.client_say__ENA[w_idx];
    end
  end

  assign w_fire = w_can_issue & (|bus.client_say__ENA);
  assign w_sel  = w_fire ? w_win : r_rr_ptr;

  assign bus.client_say__RDY = w_rdy;
  assign bus.echo_say__ENA   = w_fire;
  assign bus.echo_say_meth   = bus.client_say_meth[w_sel*DATA_W +: DATA_W];
  assign bus.echo_say_v      = bus.client_say_v[w_sel*DATA_W +: DATA_W];

  assign w_head     = r_tags[r_rd_ptr];
  assign w_occ_nz   = (r_occ != '0);
  assign w_head_rdy = bus.client_heard__RDY[w_head];
  // A response with no outstanding tag is dropped rather than popped.
  assign w_pop      = bus.echo_heard__ENA & w_occ_nz;

  assign bus.echo_heard__RDY   = w_occ_nz & w_head_rdy;
  assign bus.client_heard__ENA = w_pop ? (NUM_CLIENTS'(1) << w_head) : '0;
  assign bus.client_heard_meth = bus.echo_heard_meth;
  assign bus.client_heard_v    = bus.echo_heard_v;

  assign bus.echo_rule_enable[0] = bus.echo_rule_ready[0] & bus.sched_enable;
  assign bus.echo_rule_enable[1] = bus.echo_rule_ready[1] & w_occ_nz & w_head_rdy;

  assign bus.issued_count    = r_issued;
  assign bus.completed_count = r_completed;

  assign w_rd_next = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
  assign w_wr_next = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + PW'(1);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_rr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_occ       <= '0;
      r_issued    <= '0;
      r_completed <= '0;
      for (int t = 0; t < TAG_DEPTH; t++) begin
        r_tags[t] <= '0;
      end
    end else begin
      if (w_fire) begin
        r_tags[r_wr_ptr] <= w_win;
        r_wr_ptr         <= w_wr_next;
        r_rr_ptr         <= w_win + CW'(1);
        r_issued         <= r_issued + 32'd1;
      end
      if (w_pop) begin
        r_rd_ptr    <= w_rd_next;
        r_completed <= r_completed + 32'd1;
      end
      case ({w_fire, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_echo_client_scheduler.sv
//==============================================================================
// Module : tb_echo_client_scheduler
// Scheduler bench with a two-stage in-order Echo engine model and a scoreboard.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_echo_client_scheduler;
  localparam int N  = 4;
  localparam int TD = 2;
  localparam int DW = 32;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  echo_client_scheduler_if #(.NUM_CLIENTS(N), .DATA_W(DW)) bus ();

  echo_client_scheduler #(.NUM_CLIENTS(N), .TAG_DEPTH(TD), .DATA_W(DW)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Engine model: say -> delay slot -> respond slot -> heard
  logic          e_say_en  = 1'b1;
  logic          inj_heard = 1'b0;
  logic          e_d_valid = 1'b0;
  logic          e_r_valid = 1'b0;
  logic [DW-1:0] e_d_meth = '0, e_d_v = '0, e_r_meth = '0, e_r_v = '0;

  assign bus.echo_say__RDY   = ~e_d_valid & e_say_en;
  assign bus.echo_rule_ready = {e_r_valid, e_d_valid & ~e_r_valid};
  assign bus.echo_heard__ENA = (bus.echo_rule_enable[1] & e_r_valid) | inj_heard;
  assign bus.echo_heard_meth = e_r_meth;
  assign bus.echo_heard_v    = e_r_v;

  always @(posedge CLK) begin
    if (!nRST) begin
      e_d_valid <= 1'b0;
      e_r_valid <= 1'b0;
    end else begin
      if (bus.echo_rule_enable[1] && e_r_valid) e_r_valid <= 1'b0;
      if (bus.echo_rule_enable[0]) begin
        e_r_valid <= 1'b1;
        e_r_meth  <= e_d_meth;
        e_r_v     <= e_d_v;
        e_d_valid <= 1'b0;
      end
      if (bus.echo_say__ENA) begin
        e_d_valid <= 1'b1;
        e_d_meth  <= bus.echo_say_meth;
        e_d_v     <= bus.echo_say_v;
      end
    end
  end

  // Client drivers: ENA held while requests remain; data advances per grant
  int            req_total [N];
  int            req_done  [N];
  int            seq       [N];
  logic [DW-1:0] base_meth [N];
  logic [DW-1:0] base_v    [N];
  logic [N-1:0]  fired_last;

  initial begin
    bus.client_say__ENA = '0;
    bus.client_say_meth = '0;
    bus.client_say_v    = '0;
    for (int i = 0; i < N; i++) begin
      req_done[i] = 0;
      seq[i]      = 0;
    end
    forever begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fired_last[i]) begin
          req_done[i]++;
          seq[i]++;
        end
        bus.client_say__ENA[i]            = (req_total[i] > req_done[i]);
        bus.client_say_meth[i*DW +: DW]   = base_meth[i] + DW'(seq[i]);
        bus.client_say_v[i*DW +: DW]      = base_v[i] + DW'(seq[i] * 3);
      end
    end
  end

  // Reference model and scoreboard, evaluated where inputs are stable
  typedef struct {
    int            cl;
    logic [DW-1:0] m;
    logic [DW-1:0] v;
  } exp_t;

  exp_t          exp_q[$];
  int            grant_log[$];
  int            deliver_log[$];
  int            m_rr, m_occ, m_head, m_win, m_idx, m_sel, n_pushpop;
  logic [31:0]   m_issued, m_completed;
  logic [N-1:0]  m_rdy, m_fire, m_heard, last_heard_ena;
  logic          m_can, m_blocked;
  logic [DW-1:0] last_heard_m, last_heard_v;
  exp_t          m_e;

  initial begin
    fired_last  = '0;
    m_rr        = 0;
    m_issued    = '0;
    m_completed = '0;
    n_pushpop   = 0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        exp_q.delete();
        m_rr        = 0;
        m_issued    = '0;
        m_completed = '0;
        fired_last  = '0;
      end else begin
        m_occ   = exp_q.size();
        m_head  = (m_occ != 0) ? exp_q[0].cl : 0;
        m_can   = bus.sched_enable && bus.echo_say__RDY && (m_occ < TD);
        m_rdy   = '0;
        m_blocked = 1'b0;
        m_win   = -1;
        for (int k = 0; k < N; k++) begin
          m_idx        = (m_rr + k) % N;
          m_rdy[m_idx] = m_can && !m_blocked;
          if (bus.client_say__ENA[m_idx] && !m_blocked) m_win = m_idx;
          if (bus.client_say__ENA[m_idx]) m_blocked = 1'b1;
        end
        m_fire = (m_can && m_win >= 0) ? (N'(1) << m_win) : '0;
        m_sel  = (m_fire != '0) ? m_win : m_rr;
        check("say_rdy", bus.client_say__RDY, m_rdy);
        check("say_ena", bus.echo_say__ENA, m_fire != '0);
        check("say_meth", bus.echo_say_meth, bus.client_say_meth[m_sel*DW +: DW]);
        check("say_v", bus.echo_say_v, bus.client_say_v[m_sel*DW +: DW]);
        check("issued_cnt", bus.issued_count, m_issued);
        check("completed_cnt", bus.completed_count, m_completed);
        check("heard_rdy", bus.echo_heard__RDY, (m_occ != 0) && bus.client_heard__RDY[m_head]);
        check("rule_en", bus.echo_rule_enable,
              {bus.echo_rule_ready[1] && (m_occ != 0) && bus.client_heard__RDY[m_head],
               bus.echo_rule_ready[0] && bus.sched_enable});
        m_heard = (bus.echo_heard__ENA && m_occ != 0) ? (N'(1) << m_head) : '0;
        check("heard_ena", bus.client_heard__ENA, m_heard);
        if (m_heard != '0) begin
          check("heard_meth", bus.client_heard_meth, exp_q[0].m);
          check("heard_v", bus.client_heard_v, exp_q[0].v);
          last_heard_ena = bus.client_heard__ENA;
          last_heard_m   = bus.client_heard_meth;
          last_heard_v   = bus.client_heard_v;
          deliver_log.push_back(m_head);
          void'(exp_q.pop_front());
          m_completed++;
        end
        if (m_fire != '0) begin
          m_e.cl = m_win;
          m_e.m  = bus.client_say_meth[m_win*DW +: DW];
          m_e.v  = bus.client_say_v[m_win*DW +: DW];
          exp_q.push_back(m_e);
          grant_log.push_back(m_win);
          m_rr = (m_win + 1) % N;
          m_issued++;
          if (m_heard != '0) n_pushpop++;
        end
        fired_last = m_fire;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic bit pending();
    bit p = (exp_q.size() != 0);
    for (int i = 0; i < N; i++) if (req_total[i] > req_done[i]) p = 1'b1;
    return p;
  endfunction

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 200; c++) begin
      if (!pending()) return;
      tick();
    end
    check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_issued(input logic [31:0] target);
    for (int c = 0; c < 100; c++) begin
      if (m_issued == target) return;
      tick();
    end
    check("issue_timeout", m_issued, target);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    grant_log.delete();
    deliver_log.delete();
  endtask

  int exp_t4 [6] = '{0, 1, 2, 3, 0, 2};

  initial begin
    nRST                  = 1'b0;
    bus.sched_enable      = 1'b0;
    bus.client_heard__RDY = '1;
    for (int i = 0; i < N; i++) begin
      req_total[i] = 0;
      base_meth[i] = 32'h1000_0000 * (i + 1);
      base_v[i]    = 32'h0000_0100 * (i + 1);
    end
    tick();
    tick();
    @(negedge CLK);
    check("rst_say_rdy", bus.client_say__RDY, 4'b0000);
    check("rst_say_ena", bus.echo_say__ENA, 1'b0);
    check("rst_heard_ena", bus.client_heard__ENA, 4'b0000);
    check("rst_heard_rdy", bus.echo_heard__RDY, 1'b0);
    check("rst_issued", bus.issued_count, 32'd0);
    check("rst_completed", bus.completed_count, 32'd0);
    tick();
    nRST             = 1'b1;
    bus.sched_enable = 1'b1;

    // Single request from client 2
    base_meth[2] = 32'd5;
    base_v[2]    = 32'hAB;
    req_total[2] = 1;
    wait_idle("t1");
    @(negedge CLK);
    check("t1_heard_ena", last_heard_ena, 4'b0100);
    check("t1_heard_meth", last_heard_m, 32'd5);
    check("t1_heard_v", last_heard_v, 32'hAB);
    check("t1_issued", bus.issued_count, 32'd1);
    check("t1_completed", bus.completed_count, 32'd1);

    // All clients continuously requesting from rr_ptr = 0
    tick();
    do_reset();
    for (int i = 0; i < N; i++) req_total[i] += 2;
    wait_idle("t2");
    check("t2_grants", grant_log.size(), 8);
    for (int g = 0; g < 8; g++) check("t2_order", grant_log[g], g % N);

    // Client 1 response held back with FIFO full
    grant_log.delete();
    deliver_log.delete();
    bus.client_heard__RDY = 4'b1101;
    req_total[1]++;
    req_total[3]++;
    wait_issued(m_issued + 2);
    req_total[0]++;
    repeat (10) tick();
    @(negedge CLK);
    check("t3_full_rdy", bus.client_say__RDY, 4'b0000);
    check("t3_rule1", bus.echo_rule_enable[1], 1'b0);
    check("t3_no_heard", bus.client_heard__ENA, 4'b0000);
    tick();
    bus.client_heard__RDY = '1;
    wait_idle("t3");
    check("t3_ndeliv", deliver_log.size(), 3);
    check("t3_first", deliver_log[0], 1);
    check("t3_second", deliver_log[1], 3);
    check("t3_third", deliver_log[2], 0);

    // Six transactions across pointer wrap, pushes overlapping pops
    do_reset();
    n_pushpop = 0;
    req_total[0] += 2;
    req_total[1] += 1;
    req_total[2] += 2;
    req_total[3] += 1;
    wait_idle("t4");
    check("t4_ndeliv", deliver_log.size(), 6);
    for (int g = 0; g < 6; g++) check("t4_order", deliver_log[g], exp_t4[g]);
    check("t4_pushpop", n_pushpop != 0, 1'b1);

    // sched_enable low: delay stage frozen, respond stage drains
    deliver_log.delete();
    bus.client_heard__RDY = 4'b1110;
    req_total[0]++;
    wait_issued(m_issued + 1);
    req_total[1]++;
    wait_issued(m_issued + 1);
    bus.sched_enable      = 1'b0;
    bus.client_heard__RDY = '1;
    req_total[2]++;
    repeat (5) tick();
    @(negedge CLK);
    check("t5_rdy", bus.client_say__RDY, 4'b0000);
    check("t5_rule", bus.echo_rule_enable, 2'b00);
    check("t5_ndeliv", deliver_log.size(), 1);
    check("t5_first", deliver_log[0], 0);
    tick();
    bus.sched_enable = 1'b1;
    wait_idle("t5");
    check("t5_ndeliv_end", deliver_log.size(), 3);
    check("t5_second", deliver_log[1], 1);
    check("t5_third", deliver_log[2], 2);

    // Reset with two requests in flight
    bus.client_heard__RDY = '0;
    req_total[1]++;
    req_total[3]++;
    wait_issued(m_issued + 2);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    bus.client_heard__RDY = '1;
    grant_log.delete();
    deliver_log.delete();
    @(negedge CLK);
    check("t6_issued", bus.issued_count, 32'd0);
    check("t6_completed", bus.completed_count, 32'd0);
    check("t6_heard_rdy", bus.echo_heard__RDY, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge CLK);
      check("t6_quiet", bus.client_heard__ENA, 4'b0000);
    end
    tick();
    req_total[1]++;
    req_total[3]++;
    wait_idle("t6");
    check("t6_grant0", grant_log[0], 1);
    check("t6_grant1", grant_log[1], 3);

    // Spurious engine response with an empty FIFO
    inj_heard = 1'b1;
    @(negedge CLK);
    check("t7_heard_ena", bus.client_heard__ENA, 4'b0000);
    tick();
    inj_heard = 1'b0;
    @(negedge CLK);
    check("t7_completed", bus.completed_count, 32'd2);
    check("t7_issued", bus.issued_count, 32'd2);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
